// File: rtl/legv8_pkg.sv
// legv8_pkg: opcodes, ALU function selects, condition codes, FSM states and control word
package legv8_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_EXEC, ST_RESP} state_t;
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ANDS = 11'b11101010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [9:0] OP_ADDI  = 10'b1001000100;
  localparam logic [9:0] OP_ADDIS = 10'b1011000100;
  localparam logic [9:0] OP_SUBI  = 10'b1101000100;
  localparam logic [9:0] OP_SUBIS = 10'b1111000100;
  localparam logic [9:0] OP_ANDI  = 10'b1001001000;
  localparam logic [9:0] OP_ANDIS = 10'b1111001000;
  localparam logic [9:0] OP_ORRI  = 10'b1011001000;
  localparam logic [9:0] OP_EORI  = 10'b1101001000;
  localparam logic [7:0] OP_BCOND = 8'b01010100;
  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_HS = 4'h2;
  localparam logic [3:0] CC_LO = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [1:0] BSEL_RM    = 2'd0;
  localparam logic [1:0] BSEL_IMM   = 2'd1;
  localparam logic [1:0] BSEL_SHAMT = 2'd2;
  localparam logic [1:0] BSEL_ZERO  = 2'd3;
  typedef struct packed {
    logic [4:0] fs;
    logic       c0;
    logic [1:0] bsel;
    logic       set_flags;
    logic       is_branch;
    logic       illegal;
  } ctl_t;
  function automatic ctl_t mk(input logic [4:0] fs, input logic [1:0] bsel, input logic sf);
    return '{fs: fs, c0: fs == FS_SUB, bsel: bsel, set_flags: sf, is_branch: 1'b0, illegal: 1'b0};
  endfunction
  // opc is instr[31:21]; I-type and B.cond opcodes are its upper 10 and 8 bits
  function automatic ctl_t decode(input logic [10:0] opc);
    ctl_t c;
    c = '{fs: FS_AND, c0: 1'b0, bsel: BSEL_ZERO, set_flags: 1'b0, is_branch: 1'b0, illegal: 1'b1};
    case (opc)
      OP_ADD:  c = mk(FS_ADD, BSEL_RM, 1'b0);
      OP_ADDS: c = mk(FS_ADD, BSEL_RM, 1'b1);
      OP_SUB:  c = mk(FS_SUB, BSEL_RM, 1'b0);
      OP_SUBS: c = mk(FS_SUB, BSEL_RM, 1'b1);
      OP_AND:  c = mk(FS_AND, BSEL_RM, 1'b0);
      OP_ANDS: c = mk(FS_AND, BSEL_RM, 1'b1);
      OP_ORR:  c = mk(FS_ORR, BSEL_RM, 1'b0);
      OP_EOR:  c = mk(FS_EOR, BSEL_RM, 1'b0);
      OP_LSL:  c = mk(FS_LSL, BSEL_SHAMT, 1'b0);
      OP_LSR:  c = mk(FS_LSR, BSEL_SHAMT, 1'b0);
      default: ;
    endcase
    case (opc[10:1])
      OP_ADDI:  c = mk(FS_ADD, BSEL_IMM, 1'b0);
      OP_ADDIS: c = mk(FS_ADD, BSEL_IMM, 1'b1);
      OP_SUBI:  c = mk(FS_SUB, BSEL_IMM, 1'b0);
      OP_SUBIS: c = mk(FS_SUB, BSEL_IMM, 1'b1);
      OP_ANDI:  c = mk(FS_AND, BSEL_IMM, 1'b0);
      OP_ANDIS: c = mk(FS_AND, BSEL_IMM, 1'b1);
      OP_ORRI:  c = mk(FS_ORR, BSEL_IMM, 1'b0);
      OP_EORI:  c = mk(FS_EOR, BSEL_IMM, 1'b0);
      default: ;
    endcase
    if (opc[10:3] == OP_BCOND)
      c = '{fs: FS_AND, c0: 1'b0, bsel: BSEL_ZERO, set_flags: 1'b0, is_branch: 1'b1, illegal: 1'b0};
    return c;
  endfunction
endpackage

// File: rtl/legv8_cond_eval.sv
// legv8_cond_eval: B.cond condition evaluation against {V,C,N,Z}
module legv8_cond_eval
  import legv8_pkg::*;
(
  input  logic [3:0] i_flags,
  input  logic [3:0] i_cond,
  output logic       o_taken
);
  logic w_v, w_c, w_n, w_z;
  assign {w_v, w_c, w_n, w_z} = i_flags;
  // Condition truth table; 1110/1111 fall to always-taken
  always_comb begin
    o_taken = 1'b1;
    case (i_cond)
      CC_EQ: o_taken = w_z;
      CC_NE: o_taken = !w_z;
      CC_HS: o_taken = w_c;
      CC_LO: o_taken = !w_c;
      CC_MI: o_taken = w_n;
      CC_PL: o_taken = !w_n;
      CC_VS: o_taken = w_v;
      CC_VC: o_taken = !w_v;
      CC_HI: o_taken = w_c && !w_z;
      CC_LS: o_taken = !(w_c && !w_z);
      CC_GE: o_taken = w_n == w_v;
      CC_LT: o_taken = w_n != w_v;
      CC_GT: o_taken = !w_z && (w_n == w_v);
      CC_LE: o_taken = !(!w_z && (w_n == w_v));
      default: o_taken = 1'b1;
    endcase
  end
endmodule

// File: rtl/legv8_exec_ctrl.sv
// legv8_exec_ctrl: execute-stage controller driving the LEGv8 ALU and NZCV flags
module legv8_exec_ctrl
  import legv8_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_instr_valid,
  output logic        o_instr_ready,
  input  logic [31:0] i_instr,
  input  logic [63:0] i_op_a,
  input  logic [63:0] i_op_b,
  output logic [63:0] o_alu_a,
  output logic [63:0] o_alu_b,
  output logic [4:0]  o_alu_fs,
  output logic        o_alu_c0,
  input  logic [63:0] i_alu_f,
  input  logic [3:0]  i_alu_status,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic [63:0] o_res_data,
  output logic [4:0]  o_res_rd,
  output logic        o_res_we,
  output logic        o_res_taken,
  output logic        o_res_illegal,
  output logic [3:0]  o_flags
);
  state_t      r_state, w_next;
  logic [10:0] r_opc;
  logic [11:0] r_imm;
  logic [4:0]  r_rd;
  logic [63:0] r_op_a, r_op_b;
  ctl_t        r_ctl;
  logic [3:0]  r_flags;
  logic [63:0] r_res_data;
  logic [4:0]  r_res_rd;
  logic        r_res_we, r_res_taken, r_res_illegal;
  logic        w_exec, w_no_alu, w_taken, w_unused_rn;
  logic [63:0] w_b;
  assign w_unused_rn = ^i_instr[9:5];
  legv8_cond_eval u_cond (.i_flags(r_flags), .i_cond(r_rd[3:0]), .o_taken(w_taken));
  // State register
  always_ff @(posedge i_clock) r_state <= i_reset ? ST_IDLE : w_next;
  // Next state: fixed DECODE/EXEC walk, RESP holds until consumer accepts
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = i_instr_valid ? ST_DECODE : ST_IDLE;
      ST_DECODE: w_next = ST_EXEC;
      ST_EXEC:   w_next = ST_RESP;
      default:   w_next = i_res_ready ? ST_IDLE : ST_RESP;
    endcase
  end
  assign w_exec   = r_state == ST_EXEC;
  assign w_no_alu = r_ctl.is_branch || r_ctl.illegal;
  assign w_b = r_ctl.bsel == BSEL_RM    ? r_op_b :
               r_ctl.bsel == BSEL_IMM   ? {52'b0, r_imm} :
               r_ctl.bsel == BSEL_SHAMT ? {58'b0, r_imm[5:0]} : '0;
  assign o_instr_ready = r_state == ST_IDLE;
  assign o_alu_a  = w_exec && !w_no_alu ? r_op_a : '0;
  assign o_alu_b  = w_exec ? w_b : '0;
  assign o_alu_fs = w_exec ? r_ctl.fs : '0;
  assign o_alu_c0 = w_exec && r_ctl.c0;
  assign o_res_valid   = r_state == ST_RESP;
  assign o_res_data    = r_res_data;
  assign o_res_rd      = r_res_rd;
  assign o_res_we      = r_res_we;
  assign o_res_taken   = r_res_taken;
  assign o_res_illegal = r_res_illegal;
  assign o_flags       = r_flags;
  // Operand latch, control-word register, ALU capture and flag update
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_opc         <= '0;
      r_imm         <= '0;
      r_rd          <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_ctl         <= '0;
      r_flags       <= RESET_FLAGS;
      r_res_data    <= '0;
      r_res_rd      <= '0;
      r_res_we      <= 1'b0;
      r_res_taken   <= 1'b0;
      r_res_illegal <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && i_instr_valid) begin
        r_opc  <= i_instr[31:21];
        r_imm  <= i_instr[21:10];
        r_rd   <= i_instr[4:0];
        r_op_a <= i_op_a;
        r_op_b <= i_op_b;
      end
      if (r_state == ST_DECODE) r_ctl <= decode(r_opc);
      if (w_exec) begin
        r_res_data    <= w_no_alu ? '0 : i_alu_f;
        r_res_rd      <= r_rd;
        r_res_we      <= !w_no_alu && r_rd != 5'd31;
        r_res_taken   <= r_ctl.is_branch && w_taken;
        r_res_illegal <= r_ctl.illegal;
        if (r_ctl.set_flags) r_flags <= i_alu_status;
      end
    end
  end
endmodule

// File: tb/tb_legv8_exec_ctrl.sv
// tb_legv8_exec_ctrl: directed table, reset sequences and randomized run against a behavioural model
module tb_legv8_exec_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, instr_valid, instr_ready, res_valid, res_ready;
  logic [31:0] instr;
  logic [63:0] op_a, op_b, alu_a, alu_b, alu_f, res_data;
  logic [4:0]  alu_fs, res_rd;
  logic        alu_c0, res_we, res_taken, res_illegal;
  logic [3:0]  alu_status, flags;
  int n_tests = 0, n_fail = 0;

  legv8_exec_ctrl dut (
    .i_clock(clk), .i_reset(rst), .i_instr_valid(instr_valid), .o_instr_ready(instr_ready),
    .i_instr(instr), .i_op_a(op_a), .i_op_b(op_b), .o_alu_a(alu_a), .o_alu_b(alu_b),
    .o_alu_fs(alu_fs), .o_alu_c0(alu_c0), .i_alu_f(alu_f), .i_alu_status(alu_status),
    .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_data(res_data), .o_res_rd(res_rd),
    .o_res_we(res_we), .o_res_taken(res_taken), .o_res_illegal(res_illegal), .o_flags(flags)
  );

  logic [63:0] ax, ay;
  logic [64:0] asum;
  always_comb begin
    ax = alu_fs[1] ? ~alu_a : alu_a;
    ay = alu_fs[0] ? ~alu_b : alu_b;
    asum = {1'b0, ax} + {1'b0, ay} + {64'b0, alu_c0};
    alu_f = '0;
    case (alu_fs[4:2])
      3'b000: alu_f = ax & ay;
      3'b001: alu_f = ax | ay;
      3'b010: alu_f = asum[63:0];
      3'b011: alu_f = ax ^ ay;
      3'b100: alu_f = ax << ay[5:0];
      3'b101: alu_f = ax >> ay[5:0];
      default: alu_f = '0;
    endcase
    alu_status = {alu_fs[4:2] == 3'b010 && ax[63] == ay[63] && asum[63] != ax[63],
                  alu_fs[4:2] == 3'b010 && asum[64], alu_f[63], alu_f == 64'd0};
  end

  typedef enum int {M_ADD, M_ADDS, M_SUB, M_SUBS, M_AND, M_ANDS, M_ORR, M_EOR, M_LSL, M_LSR,
                    M_ADDI, M_ADDIS, M_SUBI, M_SUBIS, M_ANDI, M_ANDIS, M_ORRI, M_EORI, M_B, M_ILL} mn_t;
  typedef struct {
    logic [63:0] data;
    logic        we, taken, ill;
    logic [3:0]  flags;
    logic [4:0]  fs;
    logic        c0;
    logic [63:0] alub;
  } exp_t;
  typedef struct {
    logic [31:0] w;
    logic [63:0] a, b;
    int          bp;
    exp_t        e;
  } vec_t;

  function automatic logic [31:0] enc(mn_t m, logic [4:0] rd, logic [11:0] imm, logic [3:0] cc);
    case (m)
      M_ADD:   return {11'b10001011000, 5'd2, imm[5:0], 5'd9, rd};
      M_ADDS:  return {11'b10101011000, 5'd2, imm[5:0], 5'd9, rd};
      M_SUB:   return {11'b11001011000, 5'd2, imm[5:0], 5'd9, rd};
      M_SUBS:  return {11'b11101011000, 5'd2, imm[5:0], 5'd9, rd};
      M_AND:   return {11'b10001010000, 5'd2, imm[5:0], 5'd9, rd};
      M_ANDS:  return {11'b11101010000, 5'd2, imm[5:0], 5'd9, rd};
      M_ORR:   return {11'b10101010000, 5'd2, imm[5:0], 5'd9, rd};
      M_EOR:   return {11'b11001010000, 5'd2, imm[5:0], 5'd9, rd};
      M_LSL:   return {11'b11010011011, 5'd2, imm[5:0], 5'd9, rd};
      M_LSR:   return {11'b11010011010, 5'd2, imm[5:0], 5'd9, rd};
      M_ADDI:  return {10'b1001000100, imm, 5'd9, rd};
      M_ADDIS: return {10'b1011000100, imm, 5'd9, rd};
      M_SUBI:  return {10'b1101000100, imm, 5'd9, rd};
      M_SUBIS: return {10'b1111000100, imm, 5'd9, rd};
      M_ANDI:  return {10'b1001001000, imm, 5'd9, rd};
      M_ANDIS: return {10'b1111001000, imm, 5'd9, rd};
      M_ORRI:  return {10'b1011001000, imm, 5'd9, rd};
      M_EORI:  return {10'b1101001000, imm, 5'd9, rd};
      M_B:     return {8'b01010100, 19'd0, 1'b0, cc};
      default: return {8'h00, imm, imm};
    endcase
  endfunction

  function automatic logic cond_ok(logic [3:0] f, logic [3:0] cc);
    logic v, c, n, z;
    {v, c, n, z} = f;
    case (cc)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !(c && !z);
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && n == v;
      4'hD: return !(!z && n == v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic exp_t model(mn_t m, logic [63:0] a, b, logic [11:0] imm, logic [4:0] rd,
                                 logic [3:0] cc, logic [3:0] f);
    exp_t e;
    logic [63:0] y;
    logic [64:0] s;
    logic v, c;
    e = '{64'd0, 1'b0, 1'b0, 1'b0, f, 5'd0, 1'b0, 64'd0};
    v = 1'b0;
    c = 1'b0;
    y = (m inside {M_ADDI, M_ADDIS, M_SUBI, M_SUBIS, M_ANDI, M_ANDIS, M_ORRI, M_EORI}) ? {52'd0, imm} :
        (m inside {M_LSL, M_LSR}) ? {58'd0, imm[5:0]} : (m inside {M_B, M_ILL}) ? 64'd0 : b;
    case (m)
      M_ADD, M_ADDS, M_ADDI, M_ADDIS: begin
        s = {1'b0, a} + {1'b0, y};
        e.data = s[63:0];
        c = s[64];
        v = a[63] == y[63] && s[63] != a[63];
        e.fs = 5'b01000;
      end
      M_SUB, M_SUBS, M_SUBI, M_SUBIS: begin
        e.data = a - y;
        c = a >= y;
        v = a[63] != y[63] && e.data[63] != a[63];
        e.fs = 5'b01001;
        e.c0 = 1'b1;
      end
      M_AND, M_ANDS, M_ANDI, M_ANDIS: e.data = a & y;
      M_ORR, M_ORRI: begin e.data = a | y; e.fs = 5'b00100; end
      M_EOR, M_EORI: begin e.data = a ^ y; e.fs = 5'b01100; end
      M_LSL: begin e.data = a << y; e.fs = 5'b10000; end
      M_LSR: begin e.data = a >> y; e.fs = 5'b10100; end
      M_B:   e.taken = cond_ok(f, cc);
      default: e.ill = 1'b1;
    endcase
    if (m inside {M_ADDS, M_SUBS, M_ANDS, M_ADDIS, M_SUBIS, M_ANDIS})
      e.flags = {v, c, e.data[63], e.data == 64'd0};
    e.we = !(m inside {M_B, M_ILL}) && rd != 5'd31;
    e.alub = y;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [63:0] c_alua, c_alub, c_data;
  logic [4:0]  c_fs, c_rd;
  logic        c_c0, c_we, c_tk, c_il;

  task automatic run(input logic [31:0] w, input logic [63:0] a, input logic [63:0] b, input int bp);
    int n;
    n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    chk("ready_before_issue", instr_ready, 1);
    instr = w; op_a = a; op_b = b; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0; instr = $urandom; op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
    chk("res_valid_cycle1", res_valid, 0);
    @(negedge clk);
    chk("res_valid_cycle2", res_valid, 0);
    c_alua = alu_a; c_alub = alu_b; c_fs = alu_fs; c_c0 = alu_c0;
    @(negedge clk);
    chk("res_valid_cycle3", res_valid, 1);
    n = 0;
    while (!res_valid && n < 10) begin @(negedge clk); n++; end
    c_data = res_data; c_rd = res_rd; c_we = res_we; c_tk = res_taken; c_il = res_illegal;
    for (int i = 0; i < bp; i++) begin
      instr_valid = 1'b1; instr = $urandom;
      @(negedge clk);
      chk("backpressure_hold", {res_valid, instr_ready, res_data, res_rd, res_we, res_taken, res_illegal},
          {1'b1, 1'b0, c_data, c_rd, c_we, c_tk, c_il});
    end
    instr_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("ready_after_handshake", {instr_ready, res_valid}, 2'b10);
  endtask

  task automatic check_resp(input string tag, input logic [31:0] w, input logic [63:0] a, input exp_t e);
    chk({tag, "_data"}, c_data, e.data);
    chk({tag, "_rd"}, c_rd, w[4:0]);
    chk({tag, "_we_taken_ill"}, {c_we, c_tk, c_il}, {e.we, e.taken, e.ill});
    chk({tag, "_flags"}, flags, e.flags);
    if (!e.ill) begin
      chk({tag, "_alu_fs_c0"}, {c_fs, c_c0}, {e.fs, e.c0});
      chk({tag, "_alu_b"}, c_alub, e.alub);
      chk({tag, "_alu_a"}, c_alua, (w[31:24] == 8'b01010100) ? 64'd0 : a);
    end
  endtask

  vec_t tv[14];
  logic [3:0] mflags;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; instr_valid = 1'b0; res_ready = 1'b0; instr = '0; op_a = '0; op_b = '0;
    tv[0]  = '{enc(M_SUBS, 5'd1, 12'd0, 4'd0), 64'd5, 64'd5, 0,
               '{64'd0, 1'b1, 1'b0, 1'b0, 4'b0101, 5'b01001, 1'b1, 64'd5}};
    tv[1]  = '{enc(M_B, 5'd0, 12'd0, 4'h0), 64'd1234, 64'd77, 0,
               '{64'd0, 1'b0, 1'b1, 1'b0, 4'b0101, 5'b00000, 1'b0, 64'd0}};
    tv[2]  = '{enc(M_B, 5'd0, 12'd0, 4'hC), 64'd1, 64'd2, 0,
               '{64'd0, 1'b0, 1'b0, 1'b0, 4'b0101, 5'b00000, 1'b0, 64'd0}};
    tv[3]  = '{enc(M_ADD, 5'd3, 12'd0, 4'd0), 64'd10, 64'd20, 5,
               '{64'd30, 1'b1, 1'b0, 1'b0, 4'b0101, 5'b01000, 1'b0, 64'd20}};
    tv[4]  = '{enc(M_ADDS, 5'd2, 12'd0, 4'd0), 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0,
               '{64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 4'b1010, 5'b01000, 1'b0, 64'd1}};
    tv[5]  = '{enc(M_LSL, 5'd4, 12'd63, 4'd0), 64'd1, 64'hDEAD, 0,
               '{64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 4'b1010, 5'b10000, 1'b0, 64'd63}};
    tv[6]  = '{32'hFFFF_FFFF, 64'd3, 64'd4, 2,
               '{64'd0, 1'b0, 1'b0, 1'b1, 4'b1010, 5'b00000, 1'b0, 64'd0}};
    tv[7]  = '{enc(M_SUBIS, 5'd31, 12'd7, 4'd0), 64'd7, 64'd99, 0,
               '{64'd0, 1'b0, 1'b0, 1'b0, 4'b0101, 5'b01001, 1'b1, 64'd7}};
    tv[8]  = '{enc(M_ANDS, 5'd5, 12'd0, 4'd0), 64'h8000_0000_0000_00FF, 64'hF000_0000_0000_000F, 0,
               '{64'h8000_0000_0000_000F, 1'b1, 1'b0, 1'b0, 4'b0010, 5'b00000, 1'b0, 64'hF000_0000_0000_000F}};
    tv[9]  = '{enc(M_LSR, 5'd6, 12'd4, 4'd0), 64'h8000_0000_0000_0000, 64'd1, 0,
               '{64'h0800_0000_0000_0000, 1'b1, 1'b0, 1'b0, 4'b0010, 5'b10100, 1'b0, 64'd4}};
    tv[10] = '{enc(M_B, 5'd0, 12'd0, 4'h4), 64'd0, 64'd0, 0,
               '{64'd0, 1'b0, 1'b1, 1'b0, 4'b0010, 5'b00000, 1'b0, 64'd0}};
    tv[11] = '{enc(M_EORI, 5'd7, 12'hFFF, 4'd0), 64'hFF, 64'd5, 0,
               '{64'hF00, 1'b1, 1'b0, 1'b0, 4'b0010, 5'b01100, 1'b0, 64'hFFF}};
    tv[12] = '{enc(M_B, 5'd0, 12'd0, 4'hD), 64'd0, 64'd0, 1,
               '{64'd0, 1'b0, 1'b1, 1'b0, 4'b0010, 5'b00000, 1'b0, 64'd0}};
    tv[13] = '{enc(M_SUBS, 5'd8, 12'd0, 4'd0), 64'd3, 64'd5, 0,
               '{64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 4'b0010, 5'b01001, 1'b1, 64'd5}};
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", {instr_ready, res_valid, flags, res_data, res_we, res_taken, res_illegal, alu_fs, alu_c0},
        {1'b1, 1'b0, 4'b0000, 64'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0});
    chk("reset_alu_ops", {alu_a, alu_b}, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", instr_ready, 1);

    for (int i = 0; i < 14; i++) begin
      run(tv[i].w, tv[i].a, tv[i].b, tv[i].bp);
      check_resp($sformatf("vec%0d", i), tv[i].w, tv[i].a, tv[i].e);
    end

    instr = enc(M_ADDS, 5'd2, 12'd0, 4'd0); op_a = 64'h7FFF_FFFF_FFFF_FFFF; op_b = 64'd1; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("rst_exec_in_exec_fs", alu_fs, 5'b01000);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_exec_after", {flags, res_valid, instr_ready}, {4'b0000, 1'b0, 1'b1});
    rst = 1'b0;
    @(negedge clk);
    chk("rst_exec_next", {flags, res_valid, instr_ready}, {4'b0000, 1'b0, 1'b1});

    rst = 1'b1; instr = enc(M_ADDS, 5'd2, 12'd0, 4'd0); instr_valid = 1'b1;
    @(negedge clk);
    chk("rst_priority_ready", instr_ready, 1);
    rst = 1'b0; instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_priority_no_resp", {res_valid, instr_ready}, 2'b01);
    end

    mflags = 4'b0000;
    for (int k = 0; k < 150; k++) begin
      mn_t m;
      logic [63:0] a, b;
      logic [11:0] imm;
      logic [4:0] rd;
      logic [3:0] cc;
      logic [31:0] w;
      exp_t e;
      m = mn_t'($urandom_range(0, 19));
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      imm = 12'($urandom); cc = 4'($urandom);
      rd = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom);
      case ($urandom_range(0, 3))
        0: b = a;
        1: begin a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'($urandom_range(0, 3)); end
        2: begin a = 64'($urandom_range(0, 300)); b = 64'($urandom_range(0, 300)); imm = 12'(a); end
        default: ;
      endcase
      w = enc(m, rd, imm, cc);
      e = model(m, a, b, imm, rd, cc, mflags);
      run(w, a, b, $urandom_range(0, 3));
      check_resp($sformatf("rand%0d_%s", k, m.name()), w, a, e);
      mflags = e.flags;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
